// File: rtl/test_pattern_gen.sv
// test_pattern_gen: rebuilds the column/row position from free-running syncs
// and paints each active pixel with one of eight test patterns. The output is
// two clocks behind the inputs, and the syncs are delayed by the same amount
// so that they stay aligned with the colours.
module test_pattern_gen #(
  parameter int VIDEO_WIDTH = 3,
  parameter int COUNT_WIDTH = 10,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int BAR_WIDTH   = 80,
  parameter int SQUARE_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic [2:0]             i_pattern,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic [VIDEO_WIDTH-1:0] o_r_val,
  output logic [VIDEO_WIDTH-1:0] o_g_val,
  output logic [VIDEO_WIDTH-1:0] o_b_val,
  output logic                   o_frame_start
);

  localparam logic [VIDEO_WIDTH-1:0] MAX  = {VIDEO_WIDTH{1'b1}};
  localparam logic [VIDEO_WIDTH-1:0] ZERO = {VIDEO_WIDTH{1'b0}};

  // Stage-1 state: delayed syncs, position counters and the latched pattern.
  logic                   r_hsync_d1;
  logic                   r_vsync_d1;
  logic                   r_fs_d1;
  logic [COUNT_WIDTH-1:0] r_col;
  logic [COUNT_WIDTH-1:0] r_row;
  logic [2:0]             r_pattern;
  logic [COUNT_WIDTH-1:0] r_bar_cnt;
  logic [2:0]             r_bar_idx;

  logic w_frame_rise;
  logic w_col_wrap;
  logic w_row_wrap;
  logic w_bar_wrap;
  logic w_active;
  logic w_checker;
  logic w_border;
  logic [VIDEO_WIDTH-1:0] w_r;
  logic [VIDEO_WIDTH-1:0] w_g;
  logic [VIDEO_WIDTH-1:0] w_b;

  // The previous vsync sample is the stage-1 register, so a rise is seen on
  // the very cycle the new high level arrives.
  assign w_frame_rise = i_vsync & ~r_vsync_d1;
  assign w_col_wrap   = (r_col == COUNT_WIDTH'(TOTAL_COLS - 1));
  assign w_row_wrap   = (r_row == COUNT_WIDTH'(TOTAL_ROWS - 1));
  assign w_bar_wrap   = (r_bar_cnt == COUNT_WIDTH'(BAR_WIDTH - 1));

  // Stage 1: register syncs, track position, latch pattern at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync_d1 <= 1'b1;
      r_vsync_d1 <= 1'b1;
      r_fs_d1    <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_pattern  <= 3'd0;
      r_bar_cnt  <= '0;
      r_bar_idx  <= 3'd0;
    end else begin
      r_hsync_d1 <= i_hsync;
      r_vsync_d1 <= i_vsync;
      r_fs_d1    <= w_frame_rise;
      if (w_frame_rise) begin
        // Frame start takes priority over any wrap on the same cycle.
        r_col     <= '0;
        r_row     <= '0;
        r_pattern <= i_pattern;
        r_bar_cnt <= '0;
        r_bar_idx <= 3'd0;
      end else if (w_col_wrap) begin
        r_col     <= '0;
        r_bar_cnt <= '0;
        r_bar_idx <= 3'd0;
        if (w_row_wrap) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + COUNT_WIDTH'(1);
        end
      end else begin
        r_col <= r_col + COUNT_WIDTH'(1);
        if (w_bar_wrap) begin
          r_bar_cnt <= '0;
          r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
          r_bar_cnt <= r_bar_cnt + COUNT_WIDTH'(1);
        end
      end
    end
  end

  assign w_active  = (r_col < COUNT_WIDTH'(ACTIVE_COLS)) && (r_row < COUNT_WIDTH'(ACTIVE_ROWS));
  assign w_checker = r_col[SQUARE_LOG2] ^ r_row[SQUARE_LOG2];
  assign w_border  = (r_col == COUNT_WIDTH'(0)) || (r_col == COUNT_WIDTH'(ACTIVE_COLS - 1)) ||
                     (r_row == COUNT_WIDTH'(0)) || (r_row == COUNT_WIDTH'(ACTIVE_ROWS - 1));

  // Pixel colour for the stage-1 position; blanking forces black.
  always_comb begin
    w_r = ZERO;
    w_g = ZERO;
    w_b = ZERO;
    if (w_active) begin
      case (r_pattern)
        3'd0: begin w_r = ZERO; w_g = ZERO; w_b = ZERO; end
        3'd1: begin w_r = MAX;  w_g = ZERO; w_b = ZERO; end
        3'd2: begin w_r = ZERO; w_g = MAX;  w_b = ZERO; end
        3'd3: begin w_r = ZERO; w_g = ZERO; w_b = MAX;  end
        3'd4: begin
          w_r = w_checker ? MAX : ZERO;
          w_g = w_checker ? MAX : ZERO;
          w_b = w_checker ? MAX : ZERO;
        end
        3'd5: begin
          w_r = r_bar_idx[2] ? MAX : ZERO;
          w_g = r_bar_idx[1] ? MAX : ZERO;
          w_b = r_bar_idx[0] ? MAX : ZERO;
        end
        3'd6: begin
          w_r = w_border ? MAX : ZERO;
          w_g = w_border ? MAX : ZERO;
          w_b = w_border ? MAX : ZERO;
        end
        3'd7: begin w_r = MAX; w_g = MAX; w_b = MAX; end
        default: begin w_r = ZERO; w_g = ZERO; w_b = ZERO; end
      endcase
    end else begin
      w_r = ZERO;
      w_g = ZERO;
      w_b = ZERO;
    end
  end

  // Stage 2: register colour together with the stage-1 syncs and frame flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_r_val       <= ZERO;
      o_g_val       <= ZERO;
      o_b_val       <= ZERO;
      o_frame_start <= 1'b0;
    end else begin
      o_hsync       <= r_hsync_d1;
      o_vsync       <= r_vsync_d1;
      o_r_val       <= w_r;
      o_g_val       <= w_g;
      o_b_val       <= w_b;
      o_frame_start <= r_fs_d1;
    end
  end

endmodule
